// File: rtl/dual_priority_scan.sv
// dual_priority_scan: sequential MSB-first scan reporting the top two set-bit indices of a request vector
module dual_priority_scan #(
  parameter int WIDTH  = 12,
  parameter int SCAN_W = 4,
  parameter int IDX_W  = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [IDX_W-1:0] o_first,
  output logic [IDX_W-1:0] o_second,
  output logic [WIDTH-1:0] o_first_oh,
  output logic [WIDTH-1:0] o_second_oh
);
  localparam int NCHUNK = WIDTH / SCAN_W;
  localparam int PTR_W  = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  if (WIDTH % SCAN_W != 0) begin : g_bad_width
    $error("dual_priority_scan: WIDTH must be a multiple of SCAN_W");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr;
  logic [WIDTH-1:0]   shadow;
  logic [SCAN_W-1:0]  chunk;
  logic [IDX_W-1:0]   first_n, second_n;
  logic [WIDTH-1:0]   first_oh_n, second_oh_n;
  logic               accept;

  assign chunk       = shadow[ptr*SCAN_W +: SCAN_W];
  assign o_req_ready = state == IDLE && !i_reset;
  assign o_res_valid = state == DONE;
  assign accept      = state == IDLE && i_req_valid;

  // Walk the current chunk MSB to LSB, filling whichever of first/second is still empty
  always_comb begin
    first_n  = o_first;
    second_n = o_second;
    for (int j = SCAN_W - 1; j >= 0; j--)
      if (chunk[j]) begin
        if (first_n == '0) first_n = IDX_W'(int'(ptr) * SCAN_W + j + 1);
        else if (second_n == '0) second_n = IDX_W'(int'(ptr) * SCAN_W + j + 1);
      end
    first_oh_n  = first_n  == '0 ? '0 : WIDTH'(1) << (first_n - 1'b1);
    second_oh_n = second_n == '0 ? '0 : WIDTH'(1) << (second_n - 1'b1);
  end

  // Next state: stop scanning once the second index is known or the last chunk is done
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && i_req_valid) ? SCAN :
              (state == SCAN && (second_n != '0 || ptr == '0)) ? DONE :
              (state == DONE && i_res_ready) ? IDLE : state;
  end

  // State register
  always_ff @(posedge i_clk)
    state <= i_reset ? IDLE : state_n;

  // Shadow, chunk pointer and result registers; results persist through IDLE until the next accept
  always_ff @(posedge i_clk) begin
    if (i_reset || accept) begin
      ptr         <= PTR_W'(NCHUNK - 1);
      shadow      <= i_reset ? '0 : i_req;
      o_first     <= '0;
      o_second    <= '0;
      o_first_oh  <= '0;
      o_second_oh <= '0;
    end else if (state == SCAN) begin
      o_first     <= first_n;
      o_second    <= second_n;
      o_first_oh  <= first_oh_n;
      o_second_oh <= second_oh_n;
      if (state_n == SCAN) ptr <= ptr - 1'b1;
    end
  end
endmodule

// File: tb/tb_dual_priority_scan.sv
// tb_dual_priority_scan: directed table plus random model checks for both default and 16/8 configurations
module tb_dual_priority_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_valid, a_ready, a_res_valid, a_res_ready;
  logic [11:0] a_req, a_foh, a_soh;
  logic [3:0]  a_first, a_second;

  logic        b_valid, b_ready, b_res_valid, b_res_ready;
  logic [15:0] b_req, b_foh, b_soh;
  logic [4:0]  b_first, b_second;

  dual_priority_scan dut_a (
    .i_clk(clk), .i_reset(rst), .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req(a_req),
    .o_res_valid(a_res_valid), .i_res_ready(a_res_ready), .o_first(a_first), .o_second(a_second),
    .o_first_oh(a_foh), .o_second_oh(a_soh)
  );

  dual_priority_scan #(.WIDTH(16), .SCAN_W(8)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req(b_req),
    .o_res_valid(b_res_valid), .i_res_ready(b_res_ready), .o_first(b_first), .o_second(b_second),
    .o_first_oh(b_foh), .o_second_oh(b_soh)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int idx);
    return idx == 0 ? 32'd0 : 32'd1 << (idx - 1);
  endfunction

  typedef struct {
    logic [11:0] req;
    int          first;
    int          second;
    int          s;
  } vec_t;

  vec_t tbl[10];

  task automatic wait_res_a(input int f, input int sc, input int s);
    int n;
    n = 0;
    chk("a_clear_first", a_first, 0);
    chk("a_early_valid", a_res_valid, 0);
    while (!a_res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("a_latency", n, s);
    chk("a_first", a_first, f);
    chk("a_second", a_second, sc);
    chk("a_first_oh", a_foh, oh(f));
    chk("a_second_oh", a_soh, oh(sc));
  endtask

  task automatic drain_a();
    a_res_ready = 1'b1;
    @(negedge clk);
    a_res_ready = 1'b0;
    chk("a_drain_valid", a_res_valid, 0);
    chk("a_drain_ready", a_ready, 1);
  endtask

  task automatic run_a(input logic [11:0] r, input int f, input int sc, input int s, input bit drain);
    @(negedge clk);
    chk("a_req_ready", a_ready, 1);
    a_valid = 1'b1;
    a_req = r;
    @(negedge clk);
    a_valid = 1'b0;
    a_req = ~r;
    wait_res_a(f, sc, s);
    if (drain) drain_a();
  endtask

  task automatic run_b(input logic [15:0] r);
    int f, sc, s, n;
    f = 0;
    sc = 0;
    for (int i = 15; i >= 0; i--)
      if (r[i]) begin
        if (f == 0) f = i + 1;
        else if (sc == 0) sc = i + 1;
      end
    s = (sc != 0 && sc > 8) ? 1 : 2;
    @(negedge clk);
    chk("b_req_ready", b_ready, 1);
    b_valid = 1'b1;
    b_req = r;
    @(negedge clk);
    b_valid = 1'b0;
    b_req = ~r;
    n = 0;
    while (!b_res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", n, s);
    chk("b_first", b_first, f);
    chk("b_second", b_second, sc);
    chk("b_first_oh", b_foh, oh(f));
    chk("b_second_oh", b_soh, oh(sc));
    b_res_ready = 1'b1;
    @(negedge clk);
    b_res_ready = 1'b0;
    chk("b_drain_valid", b_res_valid, 0);
  endtask

  initial begin
    tbl[0] = '{12'hC00, 12, 11, 1};
    tbl[1] = '{12'h801, 12, 1, 3};
    tbl[2] = '{12'h010, 5, 0, 3};
    tbl[3] = '{12'h000, 0, 0, 3};
    tbl[4] = '{12'h030, 6, 5, 2};
    tbl[5] = '{12'hFFF, 12, 11, 1};
    tbl[6] = '{12'h0A0, 8, 6, 2};
    tbl[7] = '{12'h003, 2, 1, 3};
    tbl[8] = '{12'h100, 9, 0, 3};
    tbl[9] = '{12'h880, 12, 8, 2};

    rst = 1'b1;
    a_valid = 1'b0; a_req = '0; a_res_ready = 1'b0;
    b_valid = 1'b0; b_req = '0; b_res_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", a_ready, 0);
      chk("rst_valid", a_res_valid, 0);
    end
    rst = 1'b0;
    #1;
    chk("rst_ready_after", a_ready, 1);
    chk("rst_first", a_first, 0);
    chk("rst_second_oh", a_soh, 0);

    foreach (tbl[i]) run_a(tbl[i].req, tbl[i].first, tbl[i].second, tbl[i].s, 1'b1);

    run_a(12'h030, 6, 5, 2, 1'b0);
    a_valid = 1'b1;
    a_req = 12'h801;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", a_res_valid, 1);
      chk("bp_ready", a_ready, 0);
      chk("bp_first", a_first, 6);
      chk("bp_second", a_second, 5);
    end
    a_res_ready = 1'b1;
    @(negedge clk);
    a_res_ready = 1'b0;
    chk("bp_drain_ready", a_ready, 1);
    chk("bp_drain_valid", a_res_valid, 0);
    chk("bp_held_first", a_first, 6);
    @(negedge clk);
    a_valid = 1'b0;
    chk("bp_accepted", a_ready, 0);
    wait_res_a(12, 1, 3);
    drain_a();

    @(negedge clk);
    a_valid = 1'b1;
    a_req = 12'hFFF;
    a_res_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", a_ready, 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_valid", a_res_valid, 0);
      chk("mid_rst_ready2", a_ready, 0);
    end
    rst = 1'b0;
    a_res_ready = 1'b0;
    #1;
    chk("mid_rst_ready_after", a_ready, 1);
    chk("mid_rst_first", a_first, 0);
    chk("mid_rst_second", a_second, 0);
    chk("mid_rst_first_oh", a_foh, 0);
    chk("mid_rst_second_oh", a_soh, 0);
    chk("mid_rst_valid_after", a_res_valid, 0);
    run_a(12'h801, 12, 1, 3, 1'b1);

    run_b(16'h8000);
    run_b(16'h0000);
    run_b(16'hC000);
    run_b(16'h0081);
    run_b(16'h8001);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (i % 3 == 1) r = r & 16'($urandom) & 16'($urandom);
      if (i % 3 == 2) r = 16'(1) << $urandom_range(15, 0);
      run_b(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
